ram_nibble_arb2: RTL and testbench

//  Parametrised nibble-masked single-array RAM shared by two requestor ports
//  (A: video scan-out, B: CPU/blitter) through a registered arbiter.

---
 rtl/ram_nibble_arb2_pkg.sv | 13 +
 rtl/ram_nibble_arb2_core.sv | 65 ++++++
 rtl/ram_nibble_arb2.sv | 135 +++++++++++++
 tb/tb_ram_nibble_arb2.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ram_nibble_arb2_pkg.sv
// Shared constants for the two-port nibble-masked RAM.
// Arbitration mode codes and requestor port identifiers.
package ram_nibble_arb2_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/ram_nibble_arb2_core.sv
// Single-port word array with per-nibble write mask.
// Registered read, plus an optional output register when READ_LAT is 2.
module ram_nibble_arb2_core
    import ram_nibble_arb2_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int NIBBLES   = 6,
    parameter int READ_LAT  = 1,
    parameter int ZERO_INIT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [NIBBLES-1:0]   we_i,
    input  logic [4*NIBBLES-1:0] wdata_i,
    output logic [4*NIBBLES-1:0] rdata_o
);

    localparam int DATA_W = 4 * NIBBLES;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;
    logic              rd_en;
    logic              clr;

    assign rd_en = en_i && (we_i == '0);
    assign clr   = (ZERO_INIT != 0) && !reset_n;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (we_i[n]) begin
                    mem_q[addr_i][4*n +: 4] <= wdata_i[4*n +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem_q[addr_i];
        end
    end

    generate
        if (READ_LAT == 2) begin : g_oreg
            logic [DATA_W-1:0] out_q;
            always_ff @(posedge clk) begin
                if (clr) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end
            assign rdata_o = out_q;
        end else begin : g_noreg
            assign rdata_o = rd_q;
        end
    endgenerate

endmodule

// File: rtl/ram_nibble_arb2.sv
// Two-requestor front end for the nibble RAM: arbiter, round-robin
// history flop and a valid/tag pipeline steering read data to its port.
module ram_nibble_arb2
    import ram_nibble_arb2_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int NIBBLES   = 6,
    parameter int READ_LAT  = 1,
    parameter int ARB_MODE  = 0,
    parameter int ZERO_INIT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [NIBBLES-1:0]   a_we,
    input  logic [4*NIBBLES-1:0] a_wdata,
    output logic                 a_ack,
    output logic                 a_rvalid,
    output logic [4*NIBBLES-1:0] a_rdata,
    input  logic                 b_req,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [NIBBLES-1:0]   b_we,
    input  logic [4*NIBBLES-1:0] b_wdata,
    output logic                 b_ack,
    output logic                 b_rvalid,
    output logic [4*NIBBLES-1:0] b_rdata
);

    localparam int DATA_W = 4 * NIBBLES;
    localparam int LAST   = READ_LAT - 1;

    logic              a_gnt;
    logic              b_gnt;
    port_e             rr_last_q;
    port_e             rr_last_d;
    logic              en;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [NIBBLES-1:0] we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] core_rdata;
    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] tag_q;
    logic [DATA_W-1:0] a_hold_q;
    logic [DATA_W-1:0] b_hold_q;

    // Contention in round-robin mode goes to the port not served last.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset_n) begin
            if (ARB_MODE == ARB_RR && a_req && b_req) begin
                a_gnt = (rr_last_q == PORT_B);
                b_gnt = (rr_last_q == PORT_A);
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (a_gnt) begin
            rr_last_d = PORT_A;
        end else if (b_gnt) begin
            rr_last_d = PORT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_last_q <= PORT_B;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    assign a_ack = a_gnt;
    assign b_ack = b_gnt;
    assign en    = a_gnt | b_gnt;
    assign addr  = b_gnt ? b_addr : a_addr;
    assign wdata = b_gnt ? b_wdata : a_wdata;
    assign we    = a_gnt ? a_we : (b_gnt ? b_we : '0);
    assign rd    = en && (we == '0);

    ram_nibble_arb2_core #(
        .ADDR_W   (ADDR_W),
        .NIBBLES  (NIBBLES),
        .READ_LAT (READ_LAT),
        .ZERO_INIT(ZERO_INIT)
    ) u_core (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (en),
        .addr_i (addr),
        .we_i   (we),
        .wdata_i(wdata),
        .rdata_o(core_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= rd;
            tag_q[0] <= b_gnt;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign a_rvalid = vld_q[LAST] && !tag_q[LAST];
    assign b_rvalid = vld_q[LAST] && tag_q[LAST];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            if (a_rvalid) a_hold_q <= core_rdata;
            if (b_rvalid) b_hold_q <= core_rdata;
        end
    end

    // Fresh data bypasses the hold register so it appears with rvalid.
    assign a_rdata = a_rvalid ? core_rdata : a_hold_q;
    assign b_rdata = b_rvalid ? core_rdata : b_hold_q;

endmodule

// File: tb/tb_ram_nibble_arb2.sv
// Directed bench: fixed-priority/latency-1 and round-robin/latency-2
// instances driven by the same requestor stimulus.
module tb_ram_nibble_arb2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, b_req;
    logic [13:0] a_addr, b_addr;
    logic [5:0]  a_we, b_we;
    logic [23:0] a_wdata, b_wdata;

    logic        a_ack0, a_rv0, b_ack0, b_rv0;
    logic [23:0] a_rd0, b_rd0;
    logic        a_ack1, a_rv1, b_ack1, b_rv1;
    logic [23:0] a_rd1, b_rd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_nibble_arb2 #(.ARB_MODE(0), .READ_LAT(1)) u0 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ack(a_ack0), .a_rvalid(a_rv0), .a_rdata(a_rd0),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ack(b_ack0), .b_rvalid(b_rv0), .b_rdata(b_rd0)
    );

    ram_nibble_arb2 #(.ARB_MODE(1), .READ_LAT(2)) u1 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ack(a_ack1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ack(b_ack1), .b_rvalid(b_rv1), .b_rdata(b_rd1)
    );

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic acc(input logic port, input logic [13:0] addr,
                       input logic [5:0] we, input logic [23:0] wd);
        @(posedge clk); #1;
        a_req = !port; a_addr = addr; a_we = we; a_wdata = wd;
        b_req = port;  b_addr = addr; b_we = we; b_wdata = wd;
        @(negedge clk);
        chk("ack_single", {a_ack0, b_ack0, a_ack1, b_ack1},
            port ? 4'b0101 : 4'b1010);
    endtask

    task automatic rd_chk(input logic port, input logic [13:0] addr,
                          input logic [23:0] exp);
        acc(port, addr, 6'h00, 24'h0);
        idle();
        @(negedge clk);
        chk("rv_lat1", {a_rv0, b_rv0, a_rv1, b_rv1},
            port ? 4'b0100 : 4'b1000);
        chk("rd_lat1", port ? b_rd0 : a_rd0, exp);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rv_lat2", {a_rv0, b_rv0, a_rv1, b_rv1},
            port ? 4'b0001 : 4'b0010);
        chk("rd_lat2", port ? b_rd1 : a_rd1, exp);
        chk("rd_hold", port ? b_rd0 : a_rd0, exp);
    endtask

    initial begin
        int a_cnt, b_cnt;
        logic ea, eb;
        reset_n = 1'b0;
        a_req = 1'b1; a_addr = '0; a_we = '0; a_wdata = '0;
        b_req = 1'b1; b_addr = '0; b_we = '0; b_wdata = '0;

        // Reset held with both requesting
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_ack", {a_ack0, b_ack0, a_ack1, b_ack1}, 4'b0000);
            chk("rst_rv", {a_rv0, b_rv0, a_rv1, b_rv1}, 4'b0000);
            chk("rst_rd", {a_rd0, b_rd0, a_rd1, b_rd1}, 96'h0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ack", {a_ack0, b_ack0, a_ack1, b_ack1}, 4'b1010);
        idle();
        repeat (3) @(posedge clk);

        // Masked write: nibbles 0 and 2 replaced
        acc(1'b1, 14'h0010, 6'h3F, 24'hABCDEF);
        acc(1'b1, 14'h0010, 6'b000101, 24'h123456);
        idle();
        @(negedge clk);
        chk("wr_no_rv", {a_rv0, b_rv0, a_rv1, b_rv1}, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_no_rv2", {a_rv0, b_rv0, a_rv1, b_rv1}, 4'b0000);
        rd_chk(1'b0, 14'h0010, 24'hABC4E6);

        // Top address, then read-after-write next cycle
        acc(1'b0, 14'h0000, 6'h3F, 24'h111111);
        acc(1'b0, 14'h3FFF, 6'h3F, 24'h000777);
        acc(1'b0, 14'h3FFF, 6'h00, 24'h0);
        idle();
        @(negedge clk);
        chk("raw_rv0", {a_rv0, b_rv0}, 2'b10);
        chk("raw_rd0", a_rd0, 24'h000777);
        @(posedge clk); #1;
        @(negedge clk);
        chk("raw_rv1", {a_rv1, b_rv1}, 2'b10);
        chk("raw_rd1", a_rd1, 24'h000777);
        rd_chk(1'b1, 14'h0000, 24'h111111);

        // Continuous contention; last served was B
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            a_req = (i < 8); a_addr = 14'h0010; a_we = '0;
            b_req = (i < 8); b_addr = 14'h3FFF; b_we = '0;
            @(negedge clk);
            if (i < 8) begin
                chk("fp_ack", {a_ack0, b_ack0}, 2'b10);
                chk("rr_ack", {a_ack1, b_ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            chk("fp_rv", {a_rv0, b_rv0}, {(i >= 1 && i <= 8), 1'b0});
            if (a_rv0) chk("fp_rd", a_rd0, 24'hABC4E6);
            ea = (i >= 2 && i <= 8 && i % 2 == 0);
            eb = (i >= 3 && i <= 9 && i % 2 == 1);
            chk("rr_rv", {a_rv1, b_rv1}, {ea, eb});
            if (a_rv1) begin
                a_cnt++;
                chk("rr_rd_a", a_rd1, 24'hABC4E6);
            end
            if (b_rv1) begin
                b_cnt++;
                chk("rr_rd_b", b_rd1, 24'h000777);
            end
        end
        chk("rr_cnt", {a_cnt[15:0], b_cnt[15:0]}, {16'd4, 16'd4});

        // Fixed priority: B only served once A drops
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            a_req = (i < 5); a_addr = 14'h0010; a_we = '0;
            b_req = (i < 6); b_addr = 14'h0000; b_we = '0;
            @(negedge clk);
            chk("fp_drop", {a_ack0, b_ack0},
                (i < 5) ? 2'b10 : ((i == 5) ? 2'b01 : 2'b00));
        end
        repeat (3) @(posedge clk);

        // Reset one cycle after a read is accepted
        acc(1'b0, 14'h0010, 6'h00, 24'h0);
        @(posedge clk); #1;
        a_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rv1", {a_rv1, b_rv1}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_rv", {a_rv0, b_rv0, a_rv1, b_rv1}, 4'b0000);
            chk("mid_rd", {a_rd0, b_rd0, a_rd1, b_rd1}, 96'h0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_chk(1'b0, 14'h0010, 24'hABC4E6);
        rd_chk(1'b1, 14'h3FFF, 24'h000777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
